// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Bridges MIPS load/store requests (lb/lbu/lh/lhu/lw/sb/sh/sw) coming out of
// the EX/MEM pipeline register onto a word-only DataMemory port.
//   - Loads read the containing word, then extract and sign/zero-extend the
//     addressed byte or halfword (big-endian lane order).
//   - Word stores are a single write cycle.
//   - Sub-word stores are read-modify-write: read the word, splice in the new
//     byte/halfword, write the word back.
//   - The pipeline is stalled while an access is in flight.
//
// Parameters
//   READ_WAIT    cycles memRead/memAddress are held before memReadData is
//                sampled (1..15)
//
// Ports
//   clk          clock
//   rst          asynchronous, active-low reset
//   reqValid     EX/MEM holds a memory instruction
//   reqStore     1 = store, 0 = load
//   reqSize      00 byte, 01 halfword, 10/11 word
//   reqUnsigned  zero-extend loads (lbu/lhu)
//   reqAddr      byte address
//   reqWData     store data (sub-word data in the low bits)
//   stall        hold the pipeline
//   ldData       extended load result (registered, holds last value)
//   ldValid      ldData valid this cycle (registered, only in DONE)
//   misaligned   alignment exception (combinational, IDLE only)
//   memAddress   word address to DataMemory, low 2 bits always 00
//   memWriteData word to DataMemory
//   memWrite     DataMemory write enable
//   memRead      DataMemory read enable
//   memReadData  DataMemory read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    input  logic        reqStore,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        stall,
    output logic [31:0] ldData,
    output logic        ldValid,
    output logic        misaligned,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Counter value on the final READ cycle, where memReadData is sampled.
    localparam logic [3:0] LAST_WAIT = 4'(READ_WAIT - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [3:0]  r_wait_cnt;

    // Captured request. Only the byte offset and the low 16 data bits are
    // kept: the word address lives in r_mem_addr, and full-word store data
    // is loaded straight into r_mem_wdata at acceptance.
    logic        r_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;

    // Registered outputs
    logic [31:0] r_ld_data;
    logic        r_ld_valid;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_write;
    logic        r_mem_read;

    // -----------------------------------------------------------------------
    // Request decode (live inputs, only meaningful in IDLE)
    // -----------------------------------------------------------------------
    logic w_req_half;
    logic w_req_word;
    logic w_req_misaligned;
    logic w_idle;
    logic w_accept;
    logic w_word_store;

    assign w_req_half       = (reqSize == 2'b01);
    assign w_req_word       = reqSize[1];           // 11 behaves as word
    assign w_req_misaligned = (w_req_half && reqAddr[0]) ||
                              (w_req_word && (reqAddr[1:0] != 2'b00));
    assign w_idle           = (r_state == ST_IDLE);

    // rst is folded in so stall/misaligned read 0 while reset is held,
    // even with a request sitting on the inputs.
    assign w_accept     = rst && w_idle && reqValid && !w_req_misaligned;
    assign w_word_store = reqStore && w_req_word;

    assign misaligned = rst && w_idle && reqValid && w_req_misaligned;
    assign stall      = w_accept ||
                        (rst && ((r_state == ST_READ) || (r_state == ST_WRITE)));

    // -----------------------------------------------------------------------
    // Captured-size decode (valid from READ onwards)
    // -----------------------------------------------------------------------
    logic w_cap_byte;
    logic w_cap_half;
    logic w_read_last;

    assign w_cap_byte  = (r_size == 2'b00);
    assign w_cap_half  = (r_size == 2'b01);
    assign w_read_last = (r_state == ST_READ) && (r_wait_cnt == LAST_WAIT);

    // -----------------------------------------------------------------------
    // Read-modify-write merge.
    // Lane gi is bits [8*gi+7 : 8*gi]. Big-endian: byte offset 0 is lane 3,
    // halfword offset 0 covers lanes 3 and 2.
    // -----------------------------------------------------------------------
    logic [31:0] w_merged;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE_OFS = 2'(3 - gi);
            localparam logic       HALF_OFS = (gi < 2) ? 1'b1 : 1'b0;
            localparam bit         HALF_HI  = (gi % 2 == 1);

            logic w_byte_hit;
            logic w_half_hit;

            assign w_byte_hit = w_cap_byte && (r_offset == LANE_OFS);
            assign w_half_hit = w_cap_half && (r_offset[1] == HALF_OFS);

            // Within a halfword the upper lane takes wdata[15:8].
            assign w_merged[8*gi +: 8] =
                w_byte_hit ? r_wdata[7:0] :
                w_half_hit ? (HALF_HI ? r_wdata[15:8] : r_wdata[7:0]) :
                             memReadData[8*gi +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Load extraction and extension
    // -----------------------------------------------------------------------
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;

    always_comb begin
        w_ld_byte = 8'h00;
        case (r_offset)
            2'd0:    w_ld_byte = memReadData[31:24];
            2'd1:    w_ld_byte = memReadData[23:16];
            2'd2:    w_ld_byte = memReadData[15:8];
            default: w_ld_byte = memReadData[7:0];
        endcase

        w_ld_half = r_offset[1] ? memReadData[15:0] : memReadData[31:16];

        if (w_cap_byte) begin
            w_ld_ext = {{24{!r_unsigned && w_ld_byte[7]}}, w_ld_byte};
        end else if (w_cap_half) begin
            w_ld_ext = {{16{!r_unsigned && w_ld_half[15]}}, w_ld_half};
        end else begin
            w_ld_ext = memReadData;
        end
    end

    // -----------------------------------------------------------------------
    // FSM and registered outputs.
    // The strobes are set on the edge that enters their state and cleared on
    // the edge that leaves it, so memRead and memWrite are never high
    // together and both drop straight to 0 on reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_store     <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_offset    <= 2'b00;
            r_wdata     <= 16'h0000;
            r_ld_data   <= 32'h0000_0000;
            r_ld_valid  <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else begin
            // ldValid is a single-cycle pulse that only lands in DONE.
            r_ld_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_store    <= reqStore;
                        r_size     <= reqSize;
                        r_unsigned <= reqUnsigned;
                        r_offset   <= reqAddr[1:0];
                        r_wdata    <= reqWData[15:0];
                        r_mem_addr <= {reqAddr[31:2], 2'b00};
                        r_wait_cnt <= 4'd0;
                        if (w_word_store) begin
                            // No read needed: write the word directly.
                            r_mem_wdata <= reqWData;
                            r_mem_write <= 1'b1;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    if (w_read_last) begin
                        // memReadData is sampled here straight into the
                        // register that consumes it: the merged word for a
                        // sub-word store, or the extended result for a load.
                        r_mem_read <= 1'b0;
                        r_wait_cnt <= 4'd0;
                        if (r_store) begin
                            r_mem_wdata <= w_merged;
                            r_mem_write <= 1'b1;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_ld_data  <= w_ld_ext;
                            r_ld_valid <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end

                ST_WRITE: begin
                    r_mem_write <= 1'b0;
                    r_state     <= ST_DONE;
                end

                default: begin
                    // DONE: the request is still on the inputs but has been
                    // served; ignore it and return to IDLE.
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ldData       = r_ld_data;
    assign ldValid      = r_ld_valid;
    assign memAddress   = r_mem_addr;
    assign memWriteData = r_mem_wdata;
    assign memWrite     = r_mem_write;
    assign memRead      = r_mem_read;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Two instances: u_dut_a (READ_WAIT=2) for the functional scenarios and
// u_dut_b (READ_WAIT=3) for the back-to-back timing trace. Each has its own
// behavioural DataMemory. Expected memory writes and load results are queued
// when a request is issued and checked when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int RW_A = 2;
    localparam int RW_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reqStore;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        reqValid_a, reqValid_b;

    logic        stall_a, ldValid_a, misaligned_a, memWrite_a, memRead_a;
    logic [31:0] ldData_a, memAddress_a, memWriteData_a, memReadData_a;
    logic        stall_b, ldValid_b, misaligned_b, memWrite_b, memRead_b;
    logic [31:0] ldData_b, memAddress_b, memWriteData_b, memReadData_b;

    mem_access_unit #(.READ_WAIT(RW_A)) u_dut_a (
        .clk(clk), .rst(rst), .reqValid(reqValid_a), .reqStore(reqStore),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
        .reqWData(reqWData), .stall(stall_a), .ldData(ldData_a),
        .ldValid(ldValid_a), .misaligned(misaligned_a),
        .memAddress(memAddress_a), .memWriteData(memWriteData_a),
        .memWrite(memWrite_a), .memRead(memRead_a),
        .memReadData(memReadData_a)
    );

    mem_access_unit #(.READ_WAIT(RW_B)) u_dut_b (
        .clk(clk), .rst(rst), .reqValid(reqValid_b), .reqStore(reqStore),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
        .reqWData(reqWData), .stall(stall_b), .ldData(ldData_b),
        .ldValid(ldValid_b), .misaligned(misaligned_b),
        .memAddress(memAddress_b), .memWriteData(memWriteData_b),
        .memWrite(memWrite_b), .memRead(memRead_b),
        .memReadData(memReadData_b)
    );

    // Behavioural DataMemory: combinational read, write on the clock edge.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic        pre_we_a, pre_we_b;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we_a)        mem_a[pre_idx] <= pre_data;
        else if (memWrite_a) mem_a[memAddress_a[7:2]] <= memWriteData_a;
        if (pre_we_b)        mem_b[pre_idx] <= pre_data;
        else if (memWrite_b) mem_b[memAddress_b[7:2]] <= memWriteData_b;
    end

    assign memReadData_a = mem_a[memAddress_a[7:2]];
    assign memReadData_b = mem_b[memAddress_b[7:2]];

    // Expected contents of mem_a, maintained by the bench's own store model.
    logic [31:0] shadow_a [0:63];

    // Scoreboard queues: writes as {address, data}, loads as data.
    logic [63:0] wr_q_a [$];
    logic [31:0] ld_q_a [$];
    logic [63:0] wr_q_b [$];
    logic [31:0] ld_q_b [$];

    int checks   = 0;
    int failures = 0;
    int rd_cycles_a = 0;
    bit tb_done = 1'b0;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    function automatic logic [31:0] model_load(input logic [31:0] word,
            input logic [1:0] sz, input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        int s;
        if (sz == 2'b00) begin
            s  = 8 * (3 - int'(off));
            sh = word >> s;
            return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (sz == 2'b01) begin
            s  = off[1] ? 0 : 16;
            sh = word >> s;
            return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
        return word;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old,
            input logic [1:0] sz, input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] m;
        int s;
        if (sz[1]) return wd;
        if (sz == 2'b01) begin
            s = off[1] ? 0 : 16;
            m = 32'h0000_FFFF << s;
            return (old & ~m) | ((wd & 32'h0000_FFFF) << s);
        end
        s = 8 * (3 - int'(off));
        m = 32'h0000_00FF << s;
        return (old & ~m) | ((wd & 32'h0000_00FF) << s);
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic preload_a(input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pre_idx = idx; pre_data = data; pre_we_a = 1'b1;
        @(posedge clk); #1;
        pre_we_a = 1'b0;
        shadow_a[idx] = data;
    endtask

    task automatic preload_b(input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pre_idx = idx; pre_data = data; pre_we_b = 1'b1;
        @(posedge clk); #1;
        pre_we_b = 1'b0;
    endtask

    // Present a request to DUT A, hold it while stall is high and through
    // the following cycle, then drop it. n_stall = cycles with stall high
    // (capped at 40 so a stuck DUT cannot hang the bench).
    task automatic issue_a(input logic st, input logic [1:0] sz, input logic uns,
            input logic [31:0] addr, input logic [31:0] wd, output int n_stall);
        n_stall = 0;
        @(posedge clk); #1;
        reqStore = st; reqSize = sz; reqUnsigned = uns;
        reqAddr = addr; reqWData = wd; reqValid_a = 1'b1;
        @(negedge clk);
        while (stall_a === 1'b1 && n_stall < 40) begin
            n_stall++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        reqValid_a = 1'b0;
    endtask

    // Issue one access on DUT A with bench-computed expectations.
    task automatic access_a(input string nm, input logic st, input logic [1:0] sz,
            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
            input logic [31:0] exp_ld);
        int n, exp_n, rd0;
        logic [31:0] nw;
        logic [5:0] idx;
        idx = addr[7:2];
        if (st) begin
            nw = model_store(shadow_a[idx], sz, addr[1:0], wd);
            wr_q_a.push_back({addr[31:2], 2'b00, nw});
            shadow_a[idx] = nw;
            exp_n = sz[1] ? 2 : RW_A + 2;
        end else begin
            ld_q_a.push_back(exp_ld);
            exp_n = RW_A + 1;
        end
        rd0 = rd_cycles_a;
        issue_a(st, sz, uns, addr, wd, n);
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL %s_stall_cycles: got %0d, required %0d", nm, n, exp_n);
        end
        checks++;
        if ((rd_cycles_a - rd0) !== ((st && sz[1]) ? 0 : RW_A)) begin
            failures++;
            $display("FAIL %s_read_cycles: got %0d, required %0d", nm,
                     rd_cycles_a - rd0, (st && sz[1]) ? 0 : RW_A);
        end
        $display("txn %s st=%0d sz=%0d addr=%h wd=%h stall=%0d", nm, st, sz, addr, wd, n);
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        reqStore = 1'b0; reqSize = 2'b01; reqUnsigned = 1'b0;
        reqAddr = 32'h43; reqWData = 32'h0; reqValid_a = 1'b1; reqValid_b = 1'b0;
        pre_we_a = 1'b0; pre_we_b = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (misaligned_a !== 1'b0 || stall_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_comb_misaligned: got mis=%b stall=%b, required 0 0",
                     misaligned_a, stall_a);
        end
        reqSize = 2'b10; reqAddr = 32'h40;
        #1;
        checks++;
        if (stall_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_comb_stall: got %b, required 0", stall_a);
        end
        checks++;
        if ({ldData_a, ldValid_a, memAddress_a, memWriteData_a, memWrite_a, memRead_a} !== 99'd0) begin
            failures++;
            $display("FAIL reset_regs: got ld=%h v=%b a=%h wd=%h w=%b r=%b, required all 0",
                     ldData_a, ldValid_a, memAddress_a, memWriteData_a, memWrite_a, memRead_a);
        end
        reqValid_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_word_store_load();
        preload_a(6'd16, 32'h0);
        access_a("sw_40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0);
        access_a("lw_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    endtask

    task automatic test_load_extend();
        preload_a(6'd16, 32'h11F23344);
        access_a("lb_41",  1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'hFFFFFFF2);
        access_a("lbu_41", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'h000000F2);
        access_a("lh_42",  1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h00003344);
        access_a("lh_40",  1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h000011F2);
        access_a("lb_43",  1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'h00000044);
    endtask

    task automatic test_subword_store();
        preload_a(6'd16, 32'hAABBCCDD);
        access_a("sb_42", 1'b1, 2'b00, 1'b0, 32'h42, 32'h12345677, 32'h0);
        checks++;
        if (shadow_a[16] !== 32'hAABB77DD) begin
            failures++;
            $display("FAIL sb_model: got %h, required AABB77DD", shadow_a[16]);
        end
        preload_a(6'd16, 32'hAABBCCDD);
        access_a("sh_40", 1'b1, 2'b01, 1'b0, 32'h40, 32'h0000BEEF, 32'h0);
        access_a("lw_40b", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hBEEFCCDD);
        access_a("lhu_40", 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'h0000BEEF);
        access_a("lh_40s", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'hFFFFBEEF);
    endtask

    task automatic test_random();
        logic [1:0] sz, off;
        logic st, uns;
        logic [5:0] idx;
        logic [31:0] wd, addr;
        for (int i = 8; i < 12; i++) preload_a(6'(i), $urandom);
        for (int i = 0; i < 12; i++) begin
            sz  = 2'($urandom_range(0, 3));
            off = 2'($urandom_range(0, 3));
            if (sz == 2'b01) off[0] = 1'b0;
            if (sz[1]) off = 2'b00;
            st  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            idx = 6'($urandom_range(8, 11));
            wd  = $urandom;
            addr = {24'h0, idx, off};
            access_a($sformatf("rnd%0d", i), st, sz, uns, addr, wd,
                     model_load(shadow_a[idx], sz, off, uns));
        end
    endtask

    task automatic test_misaligned();
        int rd0;
        preload_a(6'd16, 32'h01234567);
        for (int k = 0; k < 2; k++) begin
            rd0 = rd_cycles_a;
            @(posedge clk); #1;
            reqStore = (k == 1); reqSize = (k == 1) ? 2'b10 : 2'b01;
            reqUnsigned = 1'b0; reqAddr = (k == 1) ? 32'h42 : 32'h43;
            reqWData = 32'hFFFF0000; reqValid_a = 1'b1;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if ({misaligned_a, stall_a, memRead_a, memWrite_a} !== 4'b1000) begin
                    failures++;
                    $display("FAIL misaligned_%0d: got mis=%b stall=%b rd=%b wr=%b, required 1 0 0 0",
                             k, misaligned_a, stall_a, memRead_a, memWrite_a);
                end
            end
            @(posedge clk); #1;
            reqValid_a = 1'b0;
            @(negedge clk);
            checks++;
            if (misaligned_a !== 1'b0 || rd_cycles_a !== rd0) begin
                failures++;
                $display("FAIL misaligned_%0d_after: got mis=%b reads=%0d, required 0 0",
                         k, misaligned_a, rd_cycles_a - rd0);
            end
            $display("txn misaligned k=%0d addr=%h", k, reqAddr);
        end
        checks++;
        if (mem_a[16] !== 32'h01234567) begin
            failures++;
            $display("FAIL misaligned_mem: got %h, required 01234567", mem_a[16]);
        end
    endtask

    task automatic test_reset_mid_op();
        preload_a(6'd20, 32'hAABBCCDD);
        @(posedge clk); #1;
        reqStore = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0;
        reqAddr = 32'h51; reqWData = 32'h00000011; reqValid_a = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (memRead_a !== 1'b1 || stall_a !== 1'b1) begin
            failures++;
            $display("FAIL midrst_in_read: got rd=%b stall=%b, required 1 1", memRead_a, stall_a);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({memRead_a, memWrite_a, stall_a, misaligned_a} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_strobes: got rd=%b wr=%b stall=%b mis=%b, required 0 0 0 0",
                     memRead_a, memWrite_a, stall_a, misaligned_a);
        end
        checks++;
        if (ldData_a !== 32'h0) begin
            failures++;
            $display("FAIL midrst_lddata: got %h, required 00000000", ldData_a);
        end
        reqValid_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (mem_a[20] !== 32'hAABBCCDD || stall_a !== 1'b0) begin
            failures++;
            $display("FAIL midrst_mem: got %h stall=%b, required AABBCCDD 0", mem_a[20], stall_a);
        end
        $display("txn reset mid sb addr=51");
    endtask

    task automatic test_back_to_back();
        logic [9:0] got_st, got_rd, got_wr, got_lv;
        logic [9:0] exp_st, exp_rd, exp_wr, exp_lv;
        preload_b(6'd24, 32'hCAFEF00D);
        for (int c = 0; c < 10; c++) begin
            exp_st[c] = (c <= RW_B) || (c == RW_B + 2) || (c == RW_B + 3);
            exp_rd[c] = (c >= 1) && (c <= RW_B);
            exp_wr[c] = (c == RW_B + 3);
            exp_lv[c] = (c == RW_B + 1);
        end
        ld_q_b.push_back(32'hCAFEF00D);
        wr_q_b.push_back({32'h64, 32'h01020304});
        @(posedge clk); #1;
        reqStore = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0;
        reqAddr = 32'h60; reqWData = 32'h0; reqValid_b = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            got_st[c] = stall_b; got_rd[c] = memRead_b;
            got_wr[c] = memWrite_b; got_lv[c] = ldValid_b;
            @(posedge clk); #1;
            if (c + 1 == RW_B + 2) begin
                reqStore = 1'b1; reqAddr = 32'h64; reqWData = 32'h01020304;
            end
            if (c + 1 == RW_B + 5) reqValid_b = 1'b0;
        end
        checks++;
        if (got_st !== exp_st) begin
            failures++;
            $display("FAIL b2b_stall: got %b, required %b", got_st, exp_st);
        end
        checks++;
        if (got_rd !== exp_rd) begin
            failures++;
            $display("FAIL b2b_memread: got %b, required %b", got_rd, exp_rd);
        end
        checks++;
        if (got_wr !== exp_wr) begin
            failures++;
            $display("FAIL b2b_memwrite: got %b, required %b", got_wr, exp_wr);
        end
        checks++;
        if (got_lv !== exp_lv) begin
            failures++;
            $display("FAIL b2b_ldvalid: got %b, required %b", got_lv, exp_lv);
        end
        $display("txn b2b lw 60 / sw 64 stall=%b", got_st);
    endtask

    // -----------------------------------------------------------------------
    // Main sequence with the scoreboard monitor running alongside.
    // -----------------------------------------------------------------------
    initial begin
        logic [63:0] e64;
        logic [31:0] e32;
        fork
            begin : monitor
                while (!tb_done) begin
                    @(negedge clk);
                    if (rst === 1'b1) begin
                        if (memRead_a === 1'b1) rd_cycles_a++;
                        if (memWrite_a === 1'b1) begin
                            checks++;
                            if (wr_q_a.size() == 0) begin
                                failures++;
                                $display("FAIL write_a_unexpected: got addr=%h data=%h, required no write",
                                         memAddress_a, memWriteData_a);
                            end else begin
                                e64 = wr_q_a.pop_front();
                                if ({memAddress_a, memWriteData_a} !== e64) begin
                                    failures++;
                                    $display("FAIL write_a: got addr=%h data=%h, required addr=%h data=%h",
                                             memAddress_a, memWriteData_a, e64[63:32], e64[31:0]);
                                end
                            end
                        end
                        if (ldValid_a === 1'b1) begin
                            checks++;
                            if (ld_q_a.size() == 0) begin
                                failures++;
                                $display("FAIL load_a_unexpected: got %h, required no ldValid", ldData_a);
                            end else begin
                                e32 = ld_q_a.pop_front();
                                if (ldData_a !== e32) begin
                                    failures++;
                                    $display("FAIL load_a: got %h, required %h", ldData_a, e32);
                                end
                            end
                        end
                        if (memWrite_b === 1'b1) begin
                            checks++;
                            if (wr_q_b.size() == 0) begin
                                failures++;
                                $display("FAIL write_b_unexpected: got addr=%h data=%h, required no write",
                                         memAddress_b, memWriteData_b);
                            end else begin
                                e64 = wr_q_b.pop_front();
                                if ({memAddress_b, memWriteData_b} !== e64) begin
                                    failures++;
                                    $display("FAIL write_b: got addr=%h data=%h, required addr=%h data=%h",
                                             memAddress_b, memWriteData_b, e64[63:32], e64[31:0]);
                                end
                            end
                        end
                        if (ldValid_b === 1'b1) begin
                            checks++;
                            if (ld_q_b.size() == 0) begin
                                failures++;
                                $display("FAIL load_b_unexpected: got %h, required no ldValid", ldData_b);
                            end else begin
                                e32 = ld_q_b.pop_front();
                                if (ldData_b !== e32) begin
                                    failures++;
                                    $display("FAIL load_b: got %h, required %h", ldData_b, e32);
                                end
                            end
                        end
                        if ((memRead_a && memWrite_a) || (memRead_b && memWrite_b)) begin
                            failures++;
                            $display("FAIL rd_wr_overlap: got both strobes high, required at most one");
                        end
                    end
                end
            end
            begin : stimulus
                test_reset();
                test_word_store_load();
                test_load_extend();
                test_subword_store();
                test_misaligned();
                test_random();
                test_reset_mid_op();
                test_back_to_back();
                repeat (3) @(negedge clk);
                tb_done = 1'b1;
            end
        join

        checks++;
        if (wr_q_a.size() + ld_q_a.size() + wr_q_b.size() + ld_q_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0",
                     wr_q_a.size() + ld_q_a.size() + wr_q_b.size() + ld_q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule
